// File: rtl/updn_cntr_bounded.sv
// Bounded up/down counter with runtime min/max, wrap or saturate mode,
// synchronous clear, clamped parallel load, terminal-count pulse and sticky overflow.
module updn_cntr_bounded #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cntr,
  output logic             tc,
  output logic             ovf,
  output logic             at_min,
  output logic             at_max,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_cntr;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_cntr_nxt;
  logic             w_tc_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_ld_clamp;
  logic             w_cfg_err;

  // Bounds are inconsistent when min exceeds max; the counter freezes then.
  assign w_cfg_err = (min_val > max_val);

  // Load value clamped into [min_val, max_val].
  always_comb begin
    w_ld_clamp = ld_val;
    if (ld_val < min_val) begin
      w_ld_clamp = min_val;
    end else if (ld_val > max_val) begin
      w_ld_clamp = max_val;
    end
  end

  // Next-state selection in priority order: cfg_err > clr > ld > en.
  always_comb begin
    w_cntr_nxt = r_cntr;
    w_tc_nxt   = 1'b0;
    w_ovf_nxt  = r_ovf;
    if (w_cfg_err) begin
      w_cntr_nxt = r_cntr;
    end else if (clr) begin
      w_cntr_nxt = min_val;
      w_ovf_nxt  = 1'b0;
    end else if (ld) begin
      w_cntr_nxt = w_ld_clamp;
    end else if (en) begin
      if (!dir) begin
        // Up: anything at or above max (including out-of-range) is a boundary.
        if (r_cntr < max_val) begin
          w_cntr_nxt = r_cntr + WIDTH'(1);
        end else begin
          w_cntr_nxt = sat ? max_val : min_val;
          w_tc_nxt   = 1'b1;
          w_ovf_nxt  = 1'b1;
        end
      end else begin
        // Down: anything at or below min (including out-of-range) is a boundary.
        if (r_cntr > min_val) begin
          w_cntr_nxt = r_cntr - WIDTH'(1);
        end else begin
          w_cntr_nxt = sat ? min_val : max_val;
          w_tc_nxt   = 1'b1;
          w_ovf_nxt  = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cntr <= RST_CNT;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_cntr <= w_cntr_nxt;
      r_tc   <= w_tc_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign cntr    = r_cntr;
  assign tc      = r_tc;
  assign ovf     = r_ovf;
  assign at_min  = (r_cntr == min_val);
  assign at_max  = (r_cntr == max_val);
  assign cfg_err = w_cfg_err;

endmodule

// File: tb/tb_updn_cntr_bounded.sv
// Scoreboard bench: a behavioural model predicts each edge's result, the
// prediction is queued when stimulus is applied and popped after the edge.
module tb_updn_cntr_bounded;

  typedef struct {
    int    cntr;
    bit    tc;
    bit    ovf;
    bit    at_min;
    bit    at_max;
    bit    cfg_err;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, sat = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [7:0] ld_val = '0, min_val = '0, max_val = 8'd255;
  logic [7:0] cntr;
  logic       tc, ovf, at_min, at_max, cfg_err;

  // Legacy-equivalent 4-bit instance: always enabled, counting up, wrapping 0..15.
  logic       l_en = 1'b1, l_dir = 1'b0, l_sat = 1'b0, l_clr = 1'b0, l_ld = 1'b0;
  logic [3:0] l_ld_val = '0, l_min = 4'd0, l_max = 4'd15;
  logic [3:0] l_cntr;
  logic       l_tc, l_ovf, l_at_min, l_at_max, l_cfg_err;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  int   m_cntr = 7;
  bit   m_ovf  = 1'b0;

  updn_cntr_bounded #(.WIDTH(8), .RST_VAL(7)) u_dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .clr(clr), .ld(ld),
    .ld_val(ld_val), .min_val(min_val), .max_val(max_val),
    .cntr(cntr), .tc(tc), .ovf(ovf), .at_min(at_min), .at_max(at_max), .cfg_err(cfg_err)
  );

  updn_cntr_bounded #(.WIDTH(4), .RST_VAL(0)) u_leg (
    .clk(clk), .rst(rst), .en(l_en), .dir(l_dir), .sat(l_sat), .clr(l_clr), .ld(l_ld),
    .ld_val(l_ld_val), .min_val(l_min), .max_val(l_max),
    .cntr(l_cntr), .tc(l_tc), .ovf(l_ovf), .at_min(l_at_min), .at_max(l_at_max),
    .cfg_err(l_cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, predict the result, then compare after the edge.
  task automatic step(input string tag, input bit i_en, input bit i_dir, input bit i_sat,
                      input bit i_clr, input bit i_ld, input int ldv, input int mn, input int mx);
    exp_t e;
    int   c;
    bit   t;
    en = i_en; dir = i_dir; sat = i_sat; clr = i_clr; ld = i_ld;
    ld_val = 8'(ldv); min_val = 8'(mn); max_val = 8'(mx);
    c = m_cntr;
    t = 1'b0;
    if (mn > mx) begin
      c = m_cntr;
    end else if (i_clr) begin
      c = mn; m_ovf = 1'b0;
    end else if (i_ld) begin
      c = (ldv < mn) ? mn : ((ldv > mx) ? mx : ldv);
    end else if (i_en && !i_dir) begin
      if (m_cntr >= mx) begin c = i_sat ? mx : mn; t = 1'b1; m_ovf = 1'b1; end
      else c = m_cntr + 1;
    end else if (i_en && i_dir) begin
      if (m_cntr <= mn) begin c = i_sat ? mn : mx; t = 1'b1; m_ovf = 1'b1; end
      else c = m_cntr - 1;
    end
    m_cntr = c;
    e.cntr = c; e.tc = t; e.ovf = m_ovf; e.at_min = (c == mn); e.at_max = (c == mx);
    e.cfg_err = (mn > mx); e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_cntr"},   32'(cntr),    32'(e.cntr));
      chk({e.tag, "_tc"},     32'(tc),      32'(e.tc));
      chk({e.tag, "_ovf"},    32'(ovf),     32'(e.ovf));
      chk({e.tag, "_atmin"},  32'(at_min),  32'(e.at_min));
      chk({e.tag, "_atmax"},  32'(at_max),  32'(e.at_max));
      chk({e.tag, "_cfgerr"}, 32'(cfg_err), 32'(e.cfg_err));
    end
  endtask

  initial begin
    // Reset values held while rst is asserted, across edges.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_cntr", 32'(cntr), 32'd7);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_leg_cntr", 32'(l_cntr), 32'd0);
    rst = 1'b0;

    // Legacy equivalence on the 4-bit instance while the main counter idles.
    for (int k = 1; k <= 20; k++) begin
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 255);
      chk("leg_cntr", 32'(l_cntr), 32'(k % 16));
      chk("leg_tc", 32'(l_tc), 32'(k == 16));
      chk("leg_ovf", 32'(l_ovf), 32'(k >= 16));
    end

    // Down wrap, then down saturate, in [10,20].
    step("ld12", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12, 10, 20);
    for (int k = 0; k < 4; k++) step("dn_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10, 20);
    step("ld12b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12, 10, 20);
    for (int k = 0; k < 4; k++) step("dn_sat", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 10, 20);

    // Clamp and priority in [5,9].
    step("ld_hi_clamp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 200, 5, 9);
    step("ld_lo_clamp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 5, 9);
    step("ld_over_en", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6, 5, 9);
    step("ld9", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 5, 9);
    step("up_sat_max", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 5, 9);
    step("up_sat_max2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 5, 9);
    step("clr_over_bnd", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 9);
    step("up_norm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 9);

    // Runtime bound changes with out-of-range count.
    step("ld50", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 50, 0, 255);
    step("up_above_max", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 30);
    step("ld50b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 50, 0, 100);
    step("dn_below_min", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 60, 100);
    step("up_below_min", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 120, 200);
    step("dn_above_max", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 50);

    // Config error freezes everything, then normal counting resumes.
    step("cfg_en", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8, 3);
    step("cfg_ld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 8, 3);
    step("cfg_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8, 3);
    step("cfg_dn", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8, 3);
    step("cfg_all", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 8, 3);
    step("cfg_fixed", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 255);

    // Degenerate range: every enabled step is a boundary.
    step("ld40", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40, 40, 40);
    for (int k = 0; k < 3; k++) step("eq_bnd", 1'b1, k[0], 1'b0, 1'b0, 1'b0, 0, 40, 40);

    // Async reset between edges, right after a boundary step set tc and ovf.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cntr", 32'(cntr), 32'd7);
    chk("arst_tc", 32'(tc), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    m_cntr = 7;
    m_ovf = 1'b0;
    step("post_rst_up", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 255);
    step("post_rst_dn", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 255);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
